// File: rtl/board_generator.sv
// board_generator: fills a Flood-It board with random colours, one cell per
// accepted LFSR draw, streamed row-major to the board RAM, then pulses DONE.
module board_generator #(
    parameter int          MAX_SIZE = 26,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       GENERATE,
    input  logic [4:0] SIZE,
    input  logic [3:0] COLOR_NUM,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic       CELL_WE,
    output logic [4:0] CELL_ROW,
    output logic [4:0] CELL_COL,
    output logic [2:0] CELL_COLOR
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [15:0] lfsr_reg;
    logic [4:0]  s_size_reg, s_size_next;
    logic [3:0]  s_colors_reg, s_colors_next;
    logic [4:0]  row_reg, row_next;
    logic [4:0]  col_reg, col_next;
    logic [2:0]  c00_reg, c00_next;
    logic        done_next, error_next, we_next;
    logic [4:0]  wr_row_next, wr_col_next;
    logic [2:0]  wr_color_next;

    logic [2:0]  draw;
    logic        draw_ok;
    logic        req_legal;
    logic        last_col;
    logic        last_cell;

    assign draw = lfsr_reg[2:0];

    // Legal edges are 2,6,...,26: low bits 2'b10 and within MAX_SIZE.
    assign req_legal = (SIZE[1:0] == 2'b10) && (int'(SIZE) <= MAX_SIZE)
                    && (COLOR_NUM >= 4'd2) && (COLOR_NUM <= 4'd8);

    // Cell (0,1) may not repeat (0,0), so the board never starts pre-flooded.
    assign draw_ok = ({1'b0, draw} < s_colors_reg)
                  && !((row_reg == 5'd0) && (col_reg == 5'd1) && (draw == c00_reg));

    assign last_col  = (col_reg == s_size_reg - 5'd1);
    assign last_cell = last_col && (row_reg == s_size_reg - 5'd1);

    assign BUSY = (state_reg != IDLE);

    // Free-running LFSR (x^16+x^14+x^13+x^11+1); shifts in every state so
    // the moment GENERATE is pressed decides the board.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            lfsr_reg <= SEED_EFF;
        end else begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                         lfsr_reg[15:1]};
        end
    end

    // State, request latches, cell counters and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            s_size_reg   <= 5'd0;
            s_colors_reg <= 4'd0;
            row_reg      <= 5'd0;
            col_reg      <= 5'd0;
            c00_reg      <= 3'd0;
            DONE         <= 1'b0;
            ERROR        <= 1'b0;
            CELL_WE      <= 1'b0;
            CELL_ROW     <= 5'd0;
            CELL_COL     <= 5'd0;
            CELL_COLOR   <= 3'd0;
        end else begin
            state_reg    <= state_next;
            s_size_reg   <= s_size_next;
            s_colors_reg <= s_colors_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            c00_reg      <= c00_next;
            DONE         <= done_next;
            ERROR        <= error_next;
            CELL_WE      <= we_next;
            CELL_ROW     <= wr_row_next;
            CELL_COL     <= wr_col_next;
            CELL_COLOR   <= wr_color_next;
        end
    end

    // Next-state logic: request check, draw acceptance and cell advance.
    always_comb begin
        state_next    = state_reg;
        s_size_next   = s_size_reg;
        s_colors_next = s_colors_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        c00_next      = c00_reg;
        done_next     = 1'b0;
        error_next    = 1'b0;
        we_next       = 1'b0;
        wr_row_next   = CELL_ROW;
        wr_col_next   = CELL_COL;
        wr_color_next = CELL_COLOR;

        case (state_reg)
            IDLE: begin
                if (GENERATE) begin
                    if (req_legal) begin
                        s_size_next   = SIZE;
                        s_colors_next = COLOR_NUM;
                        row_next      = 5'd0;
                        col_next      = 5'd0;
                        state_next    = FILL;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            FILL: begin
                if (draw_ok) begin
                    we_next       = 1'b1;
                    wr_row_next   = row_reg;
                    wr_col_next   = col_reg;
                    wr_color_next = draw;
                    if ((row_reg == 5'd0) && (col_reg == 5'd0)) begin
                        c00_next = draw;
                    end
                    if (last_cell) begin
                        state_next = FINISH;
                    end else if (last_col) begin
                        col_next = 5'd0;
                        row_next = row_reg + 5'd1;
                    end else begin
                        col_next = col_reg + 5'd1;
                    end
                end
            end
            FINISH: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_board_generator.sv
// Directed bench for board_generator with an LFSR model that predicts the
// colour stream and DONE cycle for each request.
module tb_board_generator;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       GENERATE = 1'b0;
    logic [4:0] SIZE = 5'd0;
    logic [3:0] COLOR_NUM = 4'd0;
    logic       BUSY, DONE, ERROR, CELL_WE;
    logic [4:0] CELL_ROW, CELL_COL;
    logic [2:0] CELL_COLOR;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int exp_color [0:675];
    int obs_color [0:675];
    int saved     [0:36];

    board_generator #(.MAX_SIZE(26), .SEED(16'hACE1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .GENERATE(GENERATE), .SIZE(SIZE),
        .COLOR_NUM(COLOR_NUM), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .CELL_WE(CELL_WE), .CELL_ROW(CELL_ROW), .CELL_COL(CELL_COL),
        .CELL_COLOR(CELL_COLOR)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    // Reference LFSR, reloaded on reset and stepped on every edge.
    always @(posedge CLOCK) begin
        if (RESET) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Predicts colours for every cell and the cycle (relative to the
    // GENERATE edge) on which DONE appears; first draw is at cycle 1.
    task automatic predict(input int size, input int colors, input logic [15:0] start,
                           output int done_k);
        logic [15:0] p;
        int row, col, c00, cyc, v;
        bit acc;
        p = start; row = 0; col = 0; c00 = -1; cyc = 1; done_k = -1;
        while (cyc < 5000) begin
            v = int'(p[2:0]);
            acc = (v < colors) && !(row == 0 && col == 1 && v == c00);
            if (acc) begin
                exp_color[row*size + col] = v;
                if (row == 0 && col == 0) c00 = v;
                if (row == size-1 && col == size-1) begin
                    done_k = cyc + 2;
                    break;
                end
                if (col == size-1) begin
                    col = 0;
                    row++;
                end else begin
                    col++;
                end
            end
            p = lfsr_step(p);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    // One board request. poke_k: cycle at which GENERATE is pulsed and SIZE
    // changed mid-run (0 = none). abort_after: assert RESET after that many
    // writes (0 = run to DONE).
    task automatic run_board(input string name, input int size, input int colors,
                             input int poke_k, input int abort_after);
        int n, idx, done_k, exp_done, k, stray;
        logic busy_at_done;
        logic [12:0] e;
        n = size * size; idx = 0; done_k = -1; busy_at_done = 1'b1;
        @(negedge CLOCK);
        GENERATE = 1'b1; SIZE = size[4:0]; COLOR_NUM = colors[3:0];
        @(negedge CLOCK);
        GENERATE = 1'b0;
        predict(size, colors, m_lfsr, exp_done);
        check_val({name, " busy_k1"}, 32'(BUSY), 1);
        check_val({name, " we_k1"}, 32'(CELL_WE), 0);
        for (k = 2; k < 3000; k++) begin
            @(negedge CLOCK);
            if (k == poke_k) begin
                GENERATE = 1'b1;
                SIZE = 5'd26;
            end else if (k == poke_k + 1) begin
                GENERATE = 1'b0;
            end
            if (CELL_WE) begin
                if (idx < n) begin
                    e = {5'(idx / size), 5'(idx % size), 3'(exp_color[idx])};
                    check_val($sformatf("%s write%0d", name, idx),
                              32'({CELL_ROW, CELL_COL, CELL_COLOR}), 32'(e));
                    obs_color[idx] = int'(CELL_COLOR);
                end else begin
                    check_val({name, " extra_write"}, idx + 1, n);
                end
                idx++;
                if (abort_after > 0 && idx == abort_after) begin
                    RESET = 1'b1;
                    @(negedge CLOCK);
                    check_val({name, " reset_outputs"},
                              32'({BUSY, DONE, ERROR, CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR}), 0);
                    RESET = 1'b0;
                    stray = 0;
                    repeat (30) begin
                        @(negedge CLOCK);
                        if (DONE || CELL_WE || BUSY) stray++;
                    end
                    check_val({name, " quiet_after_reset"}, stray, 0);
                    $display("run %s size=%0d colors=%0d aborted after %0d writes", name, size, colors, idx);
                    return;
                end
            end
            if (DONE) begin
                done_k = k;
                busy_at_done = BUSY;
                break;
            end
        end
        check_val({name, " write_count"}, idx, n);
        check_val({name, " done_cycle"}, done_k, exp_done);
        check_val({name, " busy_at_done"}, 32'(busy_at_done), 0);
        check_val({name, " c01_differs"}, 32'(obs_color[1] != obs_color[0]), 1);
        @(negedge CLOCK);
        check_val({name, " idle_after_done"}, 32'({BUSY, DONE, CELL_WE}), 0);
        $display("run %s size=%0d colors=%0d writes=%0d done_k=%0d", name, size, colors, idx, done_k);
    endtask

    task automatic run_illegal(input string name, input int size, input int colors);
        @(negedge CLOCK);
        GENERATE = 1'b1; SIZE = size[4:0]; COLOR_NUM = colors[3:0];
        @(negedge CLOCK);
        GENERATE = 1'b0;
        check_val({name, " error_k1"}, 32'({ERROR, BUSY, CELL_WE}), 32'b100);
        @(negedge CLOCK);
        check_val({name, " error_k2"}, 32'({ERROR, BUSY, CELL_WE}), 0);
        $display("illegal %s size=%0d colors=%0d error_pulse_checked", name, size, colors);
    endtask

    initial begin
        repeat (2) @(negedge CLOCK);
        check_val("reset_outputs",
                  32'({BUSY, DONE, ERROR, CELL_WE, CELL_ROW, CELL_COL, CELL_COLOR}), 0);
        RESET = 1'b0;

        run_board("s2c2", 2, 2, 0, 0);
        run_board("s26c8", 26, 8, 0, 0);

        run_illegal("s5c4", 5, 4);
        run_illegal("s6c1", 6, 1);
        run_illegal("s6c9", 6, 9);
        run_illegal("s30c4", 30, 4);

        run_board("s10poke", 10, 3, 5, 0);

        do_reset();
        repeat (3) @(negedge CLOCK);
        run_board("s14abort", 14, 4, 0, 37);
        for (int i = 0; i < 37; i++) saved[i] = obs_color[i];
        do_reset();
        repeat (3) @(negedge CLOCK);
        run_board("s14full", 14, 4, 0, 0);
        for (int i = 0; i < 37; i++)
            check_val($sformatf("replay%0d", i), obs_color[i], saved[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
